// File: rtl/mips_fetch_pkg.sv
// Shared encodings and constants for the dual-issue fetch redirect logic.
package mips_fetch_pkg;

   localparam logic [1:0] BR_KIND_BR  = 2'b00;
   localparam logic [1:0] BR_KIND_J   = 2'b01;
   localparam logic [1:0] BR_KIND_JR  = 2'b10;
   localparam logic [1:0] BR_KIND_RSV = 2'b11;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_JR_WAIT  = 2'd1,
      ST_ERR_HOLD = 2'd2
   } fetch_state_e;

   localparam logic [31:0] RESET_PC        = 32'hbfc0_0000;
   localparam logic [31:0] EXC_VECTOR_BASE = 32'hbfc0_0380;
   localparam logic [31:0] PAIR_BYTES      = 32'd8;

endpackage

// File: rtl/redirect_target_calc.sv
// Combinational redirect target for BR/J/JR plus word-alignment check.
import mips_fetch_pkg::*;

module redirect_target_calc (
   input  logic [1:0]  kind,
   input  logic [31:0] inst,
   input  logic [31:0] pc,
   input  logic [31:0] jr_data,
   output logic [31:0] target,
   output logic        misaligned
);

   logic [31:0] pc_plus4;
   logic [31:0] br_off;

   always_comb begin
      pc_plus4 = pc + 32'd4;
      br_off   = {{14{inst[15]}}, inst[15:0], 2'b00};
      case (kind)
         BR_KIND_J:  target = {pc_plus4[31:28], inst[25:0], 2'b00};
         BR_KIND_JR: target = jr_data;
         default:    target = pc_plus4 + br_off;
      endcase
      misaligned = |target[1:0];
   end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer: arbitrates exception/J/JR/branch redirects and IF squash.
import mips_fetch_pkg::*;

module fetch_redirect_ctrl #(
   parameter logic [31:0] RESET_PC    = mips_fetch_pkg::RESET_PC,
   parameter int unsigned JR_WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        br_valid,
   input  logic [1:0]  br_kind,
   input  logic        br_slot,
   input  logic        br_taken,
   input  logic [31:0] br_inst,
   input  logic [31:0] br_pc,
   input  logic [31:0] jr_data,
   input  logic        jr_data_ok,
   input  logic        exc_req,
   input  logic [31:0] exc_vector,
   output logic [31:0] fetch_pc,
   output logic        fetch_en,
   output logic        flush_if,
   output logic        kill_slot2,
   output logic        addr_err,
   output logic [31:0] bad_vaddr,
   output logic        jr_timeout
);

   localparam int CW = $clog2(JR_WAIT_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(JR_WAIT_MAX);
   localparam logic [CW-1:0] CNT_LAST = CW'(JR_WAIT_MAX - 1);

   fetch_state_e  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   bad_q, bad_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ae_q, ae_d;
   logic          to_q, to_d;

   logic [1:0]    calc_kind;
   logic [31:0]   tgt;
   logic          tgt_mis;
   logic          redir;
   logic          is_jr;

   // In JR_WAIT the ID bundle is gone; only jr_data matters.
   assign calc_kind = (state_q == ST_JR_WAIT) ? BR_KIND_JR : br_kind;

   redirect_target_calc u_calc (
      .kind       (calc_kind),
      .inst       (br_inst),
      .pc         (br_pc),
      .jr_data    (jr_data),
      .target     (tgt),
      .misaligned (tgt_mis)
   );

   assign is_jr = (br_kind == BR_KIND_JR);
   assign redir = br_valid & ~stall &
                  ((br_kind == BR_KIND_J) | is_jr |
                   ((br_kind == BR_KIND_BR) & br_taken));

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      bad_d      = bad_q;
      cnt_d      = '0;
      ae_d       = 1'b0;
      to_d       = 1'b0;
      fetch_en   = 1'b1;
      flush_if   = 1'b0;
      kill_slot2 = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (exc_req) begin
               pc_d     = exc_vector;
               flush_if = 1'b1;
            end else if (redir) begin
               flush_if   = ~br_slot;
               kill_slot2 = br_slot;
               if (is_jr && !jr_data_ok) begin
                  fetch_en = 1'b0;
                  state_d  = ST_JR_WAIT;
               end else if (tgt_mis) begin
                  state_d = ST_ERR_HOLD;
                  ae_d    = 1'b1;
                  bad_d   = tgt;
               end else begin
                  pc_d = tgt;
               end
            end else if (!stall) begin
               pc_d = pc_q + PAIR_BYTES;
            end
         end
         ST_JR_WAIT: begin
            fetch_en = 1'b0;
            if (exc_req) begin
               pc_d     = exc_vector;
               flush_if = 1'b1;
               state_d  = ST_RUN;
            end else if (jr_data_ok) begin
               if (tgt_mis) begin
                  state_d = ST_ERR_HOLD;
                  ae_d    = 1'b1;
                  bad_d   = tgt;
               end else begin
                  pc_d    = tgt;
                  state_d = ST_RUN;
               end
            end else begin
               cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
               to_d  = (cnt_q == CNT_LAST);
            end
         end
         ST_ERR_HOLD: begin
            fetch_en = 1'b0;
            if (exc_req) begin
               pc_d     = exc_vector;
               flush_if = 1'b1;
               state_d  = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_PC;
         bad_q   <= '0;
         cnt_q   <= '0;
         ae_q    <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         bad_q   <= bad_d;
         cnt_q   <= cnt_d;
         ae_q    <= ae_d;
         to_q    <= to_d;
      end
   end

   assign fetch_pc   = pc_q;
   assign addr_err   = ae_q;
   assign bad_vaddr  = bad_q;
   assign jr_timeout = to_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboard bench for fetch_redirect_ctrl: directed vectors, queued expectations.
import mips_fetch_pkg::*;

module tb_fetch_redirect_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        br_valid;
   logic [1:0]  br_kind;
   logic        br_slot;
   logic        br_taken;
   logic [31:0] br_inst;
   logic [31:0] br_pc;
   logic [31:0] jr_data;
   logic        jr_data_ok;
   logic        exc_req;
   logic [31:0] exc_vector;
   logic [31:0] fetch_pc;
   logic        fetch_en;
   logic        flush_if;
   logic        kill_slot2;
   logic        addr_err;
   logic [31:0] bad_vaddr;
   logic        jr_timeout;

   fetch_redirect_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .br_valid   (br_valid),
      .br_kind    (br_kind),
      .br_slot    (br_slot),
      .br_taken   (br_taken),
      .br_inst    (br_inst),
      .br_pc      (br_pc),
      .jr_data    (jr_data),
      .jr_data_ok (jr_data_ok),
      .exc_req    (exc_req),
      .exc_vector (exc_vector),
      .fetch_pc   (fetch_pc),
      .fetch_en   (fetch_en),
      .flush_if   (flush_if),
      .kill_slot2 (kill_slot2),
      .addr_err   (addr_err),
      .bad_vaddr  (bad_vaddr),
      .jr_timeout (jr_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [79:0] nm;
      logic [31:0] pc;
      logic        en;
      logic        fl;
      logic        k2;
      logic        ae;
      logic        to;
      logic [31:0] bv;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_bv;

   task automatic cmp(input logic [79:0] nm, input logic [79:0] fld,
                      input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %0s.%0s got %h want %h", nm, fld, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         cmp(e.nm, "fetch_pc", fetch_pc, e.pc);
         cmp(e.nm, "fetch_en", {31'd0, fetch_en}, {31'd0, e.en});
         cmp(e.nm, "flush_if", {31'd0, flush_if}, {31'd0, e.fl});
         cmp(e.nm, "kill_s2", {31'd0, kill_slot2}, {31'd0, e.k2});
         cmp(e.nm, "addr_err", {31'd0, addr_err}, {31'd0, e.ae});
         cmp(e.nm, "jr_tmo", {31'd0, jr_timeout}, {31'd0, e.to});
         cmp(e.nm, "bad_va", bad_vaddr, e.bv);
      end
   end

   task automatic idle();
      stall      = 1'b0;
      br_valid   = 1'b0;
      br_kind    = BR_KIND_BR;
      br_slot    = 1'b0;
      br_taken   = 1'b0;
      br_inst    = '0;
      br_pc      = '0;
      jr_data    = '0;
      jr_data_ok = 1'b0;
      exc_req    = 1'b0;
      exc_vector = EXC_VECTOR_BASE;
   endtask

   task automatic br(input logic [1:0] k, input logic s, input logic t,
                     input logic [31:0] inst, input logic [31:0] pc);
      br_valid = 1'b1;
      br_kind  = k;
      br_slot  = s;
      br_taken = t;
      br_inst  = inst;
      br_pc    = pc;
   endtask

   task automatic chk(input logic [79:0] nm, input logic [31:0] pc,
                      input logic en, input logic fl, input logic k2,
                      input logic ae, input logic to);
      exp_t e;
      e.nm = nm;
      e.pc = pc;
      e.en = en;
      e.fl = fl;
      e.k2 = k2;
      e.ae = ae;
      e.to = to;
      e.bv = exp_bv;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset  = 1'b0;
      exp_bv = '0;
      idle();
      @(posedge clk);
      #1;
      chk("rst", 32'hbfc00000, 1, 0, 0, 0, 0);
      reset = 1'b1;
      chk("idle0", 32'hbfc00000, 1, 0, 0, 0, 0);
      chk("idle1", 32'hbfc00008, 1, 0, 0, 0, 0);
      chk("idle2", 32'hbfc00010, 1, 0, 0, 0, 0);
      chk("idle3", 32'hbfc00018, 1, 0, 0, 0, 0);
      br(BR_KIND_BR, 1'b0, 1'b1, 32'h1000_0004, 32'hbfc00010);
      chk("beq_s1", 32'hbfc00020, 1, 1, 0, 0, 0);
      idle();
      chk("beq_tgt", 32'hbfc00024, 1, 0, 0, 0, 0);
      br(BR_KIND_J, 1'b1, 1'b0, 32'h0800_0100, 32'hbfc00014);
      chk("j_s2", 32'hbfc0002c, 1, 0, 1, 0, 0);
      idle();
      chk("j_tgt", 32'hb0000400, 1, 0, 0, 0, 0);
      br(BR_KIND_JR, 1'b0, 1'b0, '0, 32'hb0000400);
      chk("jr_req", 32'hb0000408, 0, 1, 0, 0, 0);
      idle();
      stall = 1'b1;
      chk("jr_w1", 32'hb0000408, 0, 0, 0, 0, 0);
      stall = 1'b0;
      chk("jr_w2", 32'hb0000408, 0, 0, 0, 0, 0);
      stall      = 1'b1;
      jr_data    = 32'h80001000;
      jr_data_ok = 1'b1;
      chk("jr_ok", 32'hb0000408, 0, 0, 0, 0, 0);
      idle();
      chk("jr_tgt", 32'h80001000, 1, 0, 0, 0, 0);
      br(BR_KIND_JR, 1'b1, 1'b0, '0, 32'h80001004);
      jr_data    = 32'h80001002;
      jr_data_ok = 1'b1;
      chk("jr_mis", 32'h80001008, 1, 0, 1, 0, 0);
      idle();
      exp_bv = 32'h80001002;
      chk("err_ae", 32'h80001008, 0, 0, 0, 1, 0);
      chk("err_hold", 32'h80001008, 0, 0, 0, 0, 0);
      exc_req    = 1'b1;
      exc_vector = 32'hbfc00380;
      chk("err_exc", 32'h80001008, 0, 1, 0, 0, 0);
      idle();
      chk("exc_tgt", 32'hbfc00380, 1, 0, 0, 0, 0);
      br(BR_KIND_BR, 1'b1, 1'b1, 32'h1000_0040, 32'hbfc00380);
      exc_req = 1'b1;
      chk("exc_br", 32'hbfc00388, 1, 1, 0, 0, 0);
      idle();
      chk("exc_br_t", 32'hbfc00380, 1, 0, 0, 0, 0);
      stall = 1'b1;
      chk("stall0", 32'hbfc00388, 1, 0, 0, 0, 0);
      br(BR_KIND_J, 1'b0, 1'b0, 32'h0800_0200, 32'hbfc00388);
      chk("stall_j", 32'hbfc00388, 1, 0, 0, 0, 0);
      idle();
      chk("stall_rel", 32'hbfc00388, 1, 0, 0, 0, 0);
      chk("stall_adv", 32'hbfc00390, 1, 0, 0, 0, 0);
      br(BR_KIND_BR, 1'b0, 1'b0, 32'h1000_0004, 32'hbfc00390);
      chk("bnt", 32'hbfc00398, 1, 0, 0, 0, 0);
      idle();
      chk("bnt_adv", 32'hbfc003a0, 1, 0, 0, 0, 0);
      br(BR_KIND_RSV, 1'b0, 1'b1, 32'h0800_0200, 32'hbfc003a0);
      chk("rsv", 32'hbfc003a8, 1, 0, 0, 0, 0);
      idle();
      chk("rsv_adv", 32'hbfc003b0, 1, 0, 0, 0, 0);
      br(BR_KIND_JR, 1'b0, 1'b0, '0, 32'hbfc003b0);
      jr_data    = 32'hfffffff8;
      jr_data_ok = 1'b1;
      chk("jr_top", 32'hbfc003b8, 1, 1, 0, 0, 0);
      idle();
      chk("top_pc", 32'hfffffff8, 1, 0, 0, 0, 0);
      chk("wrap", 32'h00000000, 1, 0, 0, 0, 0);
      br(BR_KIND_JR, 1'b0, 1'b0, '0, 32'h00000000);
      chk("jr_to_req", 32'h00000008, 0, 1, 0, 0, 0);
      idle();
      for (int i = 0; i < 17; i++)
         chk("jr_to_wt", 32'h00000008, 0, 0, 0, 0, (i == 15));
      exc_req    = 1'b1;
      exc_vector = 32'hbfc00380;
      chk("jrw_exc", 32'h00000008, 0, 1, 0, 0, 0);
      idle();
      chk("jrw_exc_t", 32'hbfc00380, 1, 0, 0, 0, 0);
      chk("jrw_adv", 32'hbfc00388, 1, 0, 0, 0, 0);
      br(BR_KIND_JR, 1'b1, 1'b0, '0, 32'hbfc00388);
      chk("jr_s2_req", 32'hbfc00390, 0, 0, 1, 0, 0);
      idle();
      chk("jr_s2_wt", 32'hbfc00390, 0, 0, 0, 0, 0);
      reset  = 1'b0;
      exp_bv = '0;
      chk("rst_jrw", 32'hbfc00000, 1, 0, 0, 0, 0);
      reset = 1'b1;
      chk("rst_rel", 32'hbfc00000, 1, 0, 0, 0, 0);
      chk("rst_adv", 32'hbfc00008, 1, 0, 0, 0, 0);
      for (int i = 0; i < 4 && sb.size() != 0; i++)
         @(posedge clk);
      #1;
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain left %0d want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
